// File: rtl/w5300_multi_socket_conf.sv
// w5300_multi_socket_conf
// Brings up NUM_SOCKETS W5300 sockets one after another. Each socket is a TCP
// server or UDP socket as chosen by UDP_MASK. The block drives the
// addr/wr_data/op_state handshake of the W5300 bus controller. It retries a
// socket whose status read times out, up to MAX_RETRY extra attempts. After
// bring-up, a single socket can be re-opened on request.
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   enable             starts the bring-up of all sockets (sampled in Idle)
//   addr[10:0]         {WR/RD flag, 10-bit register address}
//   wr_data[15:0]      write data (0 for reads)
//   rd_data[15:0]      read data, valid while op_state is high
//   op_state           one-cycle completion pulse from the bus controller
//   reconf_req/idx     re-open socket reconf_idx (accepted only in Done)
//   busy, done         activity / completion status
//   sock_ready, sock_fail  per-socket result flags
module w5300_multi_socket_conf #(
  parameter int          NUM_SOCKETS = 2,
  parameter logic [7:0]  UDP_MASK    = 8'h00,
  parameter logic [15:0] BASE_PORT   = 16'd7000,
  parameter logic [15:0] OP_TIMEOUT  = 16'd50,
  parameter logic [2:0]  MAX_RETRY   = 3'd2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic [10:0]            addr,
  output logic [15:0]            wr_data,
  input  logic [15:0]            rd_data,
  input  logic                   op_state,
  input  logic                   reconf_req,
  input  logic [2:0]             reconf_idx,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_SOCKETS-1:0] sock_ready,
  output logic [NUM_SOCKETS-1:0] sock_fail
);

  // W5300 register map and command values
  localparam logic       W5_WR       = 1'b1;
  localparam logic       W5_RD       = 1'b0;
  localparam logic [9:0] IDLE_REG    = 10'h3fe;
  localparam logic [9:0] SN_MR       = 10'h200;
  localparam logic [9:0] SN_CR       = 10'h202;
  localparam logic [9:0] SN_IMR      = 10'h204;
  localparam logic [9:0] SN_SSR      = 10'h208;
  localparam logic [9:0] SN_PORTR    = 10'h20a;
  localparam logic [9:0] SN_KPALVTR  = 10'h21a;
  localparam logic [7:0] CR_OPEN     = 8'h01;
  localparam logic [7:0] CR_LISTEN   = 8'h02;
  localparam logic [7:0] CR_CLOSE    = 8'h10;
  localparam logic [7:0] MR_P_TCP    = 8'h01;
  localparam logic [7:0] MR_P_UDP    = 8'h02;
  localparam logic [7:0] MR_ND_ACK   = 8'h20;
  localparam logic [7:0] IMR_TCP     = 8'h1f;  // SENDOK|TIMEOUT|RECV|DISCON|CON
  localparam logic [7:0] IMR_UDP     = 8'h1c;  // SENDOK|TIMEOUT|RECV
  localparam logic [7:0] SOCK_INIT   = 8'h13;
  localparam logic [7:0] SOCK_LISTEN = 8'h14;
  localparam logic [7:0] SOCK_UDP    = 8'h22;
  localparam logic [3:0] LAST_IDX    = 4'(NUM_SOCKETS - 1);
  localparam logic [3:0] NUM_S4      = 4'(NUM_SOCKETS);

  // Socket n registers sit at the socket-0 address plus 0x40*n.
  function automatic logic [9:0] sn_reg(input logic [9:0] base, input logic [2:0] n);
    return base + {1'b0, n, 6'b000000};
  endfunction

  typedef enum logic [3:0] {
    ST_IDLE, ST_CLOSE, ST_PARAMS, ST_OPEN, ST_WAIT_INIT,
    ST_LISTEN, ST_WAIT_STATUS, ST_NEXT, ST_DONE
  } state_t;

  state_t                 state_r, state_s;
  logic [2:0]             cur_r, cur_s, retry_r, retry_s;
  logic [1:0]             op_cnt_r, op_cnt_s;
  logic [15:0]            tmo_cnt_r, tmo_s;
  logic                   single_r, single_s;
  logic [NUM_SOCKETS-1:0] ready_r, ready_s, fail_r, fail_s;
  logic                   busy_r, done_r;
  logic [10:0]            addr_s;
  logic [15:0]            wr_data_s;
  logic                   is_udp_s, timeout_s, init_match_s, listen_match_s;
  logic [7:0]             cur_oh_s, rc_oh_s;
  logic [NUM_SOCKETS-1:0] cur_mask_s, rc_mask_s;
  logic                   unused_s;

  assign is_udp_s       = UDP_MASK[cur_r];
  assign timeout_s      = (tmo_cnt_r >= OP_TIMEOUT);
  assign init_match_s   = is_udp_s ? (rd_data[7:0] == SOCK_UDP) : (rd_data[7:0] == SOCK_INIT);
  assign listen_match_s = (rd_data[7:0] == SOCK_LISTEN);
  assign cur_oh_s       = 8'd1 << cur_r;
  assign rc_oh_s        = 8'd1 << reconf_idx;
  assign cur_mask_s     = cur_oh_s[NUM_SOCKETS-1:0];
  assign rc_mask_s      = rc_oh_s[NUM_SOCKETS-1:0];
  // Upper status byte and the one-hot bits above NUM_SOCKETS carry no information.
  assign unused_s       = ^{rd_data[15:8], cur_oh_s, rc_oh_s};

  assign addr       = addr_s;
  assign wr_data    = wr_data_s;
  assign busy       = busy_r;
  assign done       = done_r;
  assign sock_ready = ready_r;
  assign sock_fail  = fail_r;

  // Next-state, bus-access and status-flag decode
  always_comb begin
    state_s   = state_r;
    cur_s     = cur_r;
    retry_s   = retry_r;
    op_cnt_s  = op_cnt_r;
    single_s  = single_r;
    ready_s   = ready_r;
    fail_s    = fail_r;
    tmo_s     = 16'd0;
    addr_s    = {W5_RD, IDLE_REG};
    wr_data_s = 16'h0000;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_s  = ST_CLOSE;
          cur_s    = 3'd0;
          retry_s  = 3'd0;
          op_cnt_s = 2'd0;
          single_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLOSE: begin
        addr_s    = {W5_WR, sn_reg(SN_CR, cur_r)};
        wr_data_s = {8'h00, CR_CLOSE};
        if (op_state) begin
          state_s  = ST_PARAMS;
          op_cnt_s = 2'd0;
        end else begin
          state_s = ST_CLOSE;
        end
      end
      ST_PARAMS: begin
        case (op_cnt_r)
          2'd0: begin
            addr_s    = {W5_WR, sn_reg(SN_MR, cur_r)};
            wr_data_s = is_udp_s ? {8'h00, MR_P_UDP} : {8'h00, MR_ND_ACK | MR_P_TCP};
          end
          2'd1: begin
            addr_s    = {W5_WR, sn_reg(SN_PORTR, cur_r)};
            wr_data_s = BASE_PORT + {13'd0, cur_r};
          end
          2'd2: begin
            addr_s    = {W5_WR, sn_reg(SN_IMR, cur_r)};
            wr_data_s = is_udp_s ? {8'h00, IMR_UDP} : {8'h00, IMR_TCP};
          end
          default: begin
            addr_s    = {W5_WR, sn_reg(SN_KPALVTR, cur_r)};
            wr_data_s = {8'd1, 8'd1};
          end
        endcase
        // UDP sockets have no keep-alive/protocol write, so they leave after IMR.
        if (op_state) begin
          if ((op_cnt_r == 2'd3) || ((op_cnt_r == 2'd2) && is_udp_s)) begin
            state_s  = ST_OPEN;
            op_cnt_s = 2'd0;
          end else begin
            op_cnt_s = op_cnt_r + 2'd1;
          end
        end else begin
          state_s = ST_PARAMS;
        end
      end
      ST_OPEN: begin
        addr_s    = {W5_WR, sn_reg(SN_CR, cur_r)};
        wr_data_s = {8'h00, CR_OPEN};
        if (op_state) begin
          state_s = ST_WAIT_INIT;
        end else begin
          state_s = ST_OPEN;
        end
      end
      ST_WAIT_INIT: begin
        addr_s = {W5_RD, sn_reg(SN_SSR, cur_r)};
        tmo_s  = tmo_cnt_r + 16'd1;
        // A matching status wins over a timeout that lands in the same cycle.
        if (op_state && init_match_s) begin
          if (is_udp_s) begin
            ready_s = ready_r | cur_mask_s;
            state_s = ST_NEXT;
          end else begin
            state_s = ST_LISTEN;
          end
        end else if (timeout_s) begin
          if (retry_r < MAX_RETRY) begin
            retry_s = retry_r + 3'd1;
            state_s = ST_CLOSE;
          end else begin
            fail_s  = fail_r | cur_mask_s;
            state_s = ST_NEXT;
          end
        end else begin
          state_s = ST_WAIT_INIT;
        end
      end
      ST_LISTEN: begin
        addr_s    = {W5_WR, sn_reg(SN_CR, cur_r)};
        wr_data_s = {8'h00, CR_LISTEN};
        if (op_state) begin
          state_s = ST_WAIT_STATUS;
        end else begin
          state_s = ST_LISTEN;
        end
      end
      ST_WAIT_STATUS: begin
        addr_s = {W5_RD, sn_reg(SN_SSR, cur_r)};
        tmo_s  = tmo_cnt_r + 16'd1;
        if (op_state && listen_match_s) begin
          ready_s = ready_r | cur_mask_s;
          state_s = ST_NEXT;
        end else if (timeout_s) begin
          if (retry_r < MAX_RETRY) begin
            retry_s = retry_r + 3'd1;
            state_s = ST_CLOSE;
          end else begin
            fail_s  = fail_r | cur_mask_s;
            state_s = ST_NEXT;
          end
        end else begin
          state_s = ST_WAIT_STATUS;
        end
      end
      ST_NEXT: begin
        if (!single_r && ({1'b0, cur_r} < LAST_IDX)) begin
          cur_s   = cur_r + 3'd1;
          retry_s = 3'd0;
          state_s = ST_CLOSE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        if (reconf_req && ({1'b0, reconf_idx} < NUM_S4)) begin
          cur_s    = reconf_idx;
          ready_s  = ready_r & ~rc_mask_s;
          fail_s   = fail_r & ~rc_mask_s;
          retry_s  = 3'd0;
          op_cnt_s = 2'd0;
          single_s = 1'b1;
          state_s  = ST_CLOSE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cur_r     <= 3'd0;
      retry_r   <= 3'd0;
      op_cnt_r  <= 2'd0;
      tmo_cnt_r <= 16'd0;
      single_r  <= 1'b0;
      ready_r   <= '0;
      fail_r    <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cur_r     <= cur_s;
      retry_r   <= retry_s;
      op_cnt_r  <= op_cnt_s;
      tmo_cnt_r <= tmo_s;
      single_r  <= single_s;
      ready_r   <= ready_s;
      fail_r    <= fail_s;
      busy_r    <= (state_s != ST_IDLE) && (state_s != ST_DONE);
      done_r    <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_w5300_multi_socket_conf.sv
// Randomised bench for w5300_multi_socket_conf. A bus responder answers every
// access. A transaction-level model lists, per socket and per attempt, the
// register accesses the configurator must make. The DUT is checked against
// that list every cycle.
module tb_w5300_multi_socket_conf;
  localparam int          NS  = 3;
  localparam logic [7:0]  UM  = 8'h02;
  localparam logic [15:0] BP  = 16'd7000;
  localparam logic [15:0] TMO = 16'd50;
  localparam int          MAXR = 2;
  localparam int M_NORM = 0, M_SLOW = 1, M_STI = 2, M_STL = 3, M_RACE = 4;

  logic clk = 1'b0;
  logic rst, enable, op_state, reconf_req, busy, done;
  logic [2:0]  reconf_idx;
  logic [10:0] addr;
  logic [15:0] wr_data, rd_data;
  logic [NS-1:0] sock_ready, sock_fail;

  always #5 clk = ~clk;

  w5300_multi_socket_conf #(.NUM_SOCKETS(NS), .UDP_MASK(UM), .BASE_PORT(BP),
                            .OP_TIMEOUT(TMO), .MAX_RETRY(3'(MAXR))) dut (
    .clk(clk), .rst(rst), .enable(enable), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .op_state(op_state), .reconf_req(reconf_req),
    .reconf_idx(reconf_idx), .busy(busy), .done(done),
    .sock_ready(sock_ready), .sock_fail(sock_fail));

  typedef struct { logic [10:0] a; logic [15:0] d; bit tmo; } acc_t;
  acc_t exp_q[$];
  int mode [0:7][0:3];
  int att [0:7];
  bit lsn [0:7];
  logic [NS-1:0] exp_ready, exp_fail;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  function automatic logic [10:0] ra(input bit wr, input int s, input int off);
    return {wr, 10'(32'h200 + 32'h40 * s + off)};
  endfunction

  function automatic void push(input logic [10:0] a, input logic [15:0] d, input bit t);
    acc_t e;
    e.a = a; e.d = d; e.tmo = t;
    exp_q.push_back(e);
  endfunction

  // Expected access list: per socket, attempts until success or retries run out.
  task automatic build(input int first, input int last);
    for (int s = first; s <= last; s++) begin
      bit udp = UM[s];
      bit ok = 0;
      att[s] = -1;
      lsn[s] = 0;
      for (int a = 0; a <= MAXR && !ok; a++) begin
        int m = mode[s][a];
        push(ra(1, s, 'h02), 16'h0010, 0);
        push(ra(1, s, 'h00), udp ? 16'h0002 : 16'h0021, 0);
        push(ra(1, s, 'h0a), 16'(BP + 16'(s)), 0);
        push(ra(1, s, 'h04), udp ? 16'h001c : 16'h001f, 0);
        if (!udp) push(ra(1, s, 'h1a), 16'h0101, 0);
        push(ra(1, s, 'h02), 16'h0001, 0);
        if (m == M_STI) begin
          push(ra(0, s, 'h08), 16'h0000, 1);
        end else begin
          push(ra(0, s, 'h08), 16'h0000, 0);
          if (udp) ok = 1;
          else begin
            push(ra(1, s, 'h02), 16'h0002, 0);
            push(ra(0, s, 'h08), 16'h0000, m == M_STL);
            ok = (m != M_STL);
          end
        end
      end
      if (ok) exp_ready[s] = 1'b1;
      else exp_fail[s] = 1'b1;
    end
  endtask

  task automatic rand_modes(input int s);
    for (int a = 0; a < 4; a++) begin
      int m = int'($urandom_range(0, 4));
      if (UM[s] && m == M_STL) m = M_NORM;
      mode[s][a] = m;
    end
  endtask

  task automatic set_modes(input int s, input int m0, input int m1, input int m2);
    mode[s][0] = m0; mode[s][1] = m1; mode[s][2] = m2; mode[s][3] = M_NORM;
  endtask

  // Bus responder and per-cycle comparison against the expected access list
  logic [10:0] last_addr;
  int hold, vis, polls, s_i, a_i, m_i;
  bit op_prev, pulse, stk;
  logic [7:0] tgt;
  logic [15:0] rdat;
  always @(negedge clk) begin
    if (rst) begin
      op_state = 1'b0; rd_data = 16'h0; hold = 0; vis = 0; polls = 0;
      last_addr = addr; op_prev = 1'b0;
    end else begin
      if (addr !== last_addr) begin
        if (exp_q.size() > 0 && exp_q[0].tmo && last_addr == exp_q[0].a) begin
          chk("timeout_len", 32'(vis), 32'(TMO));
          void'(exp_q.pop_front());
        end
        hold = 0; vis = 0; polls = 0;
      end else begin
        vis++;
        hold = op_prev ? 0 : hold + 1;
      end
      last_addr = addr;
      if (busy && addr[9:0] != 10'h3fe) begin
        if (exp_q.size() > 0) begin
          chk("addr", 32'(addr), 32'(exp_q[0].a));
          chk("wr_data", 32'(wr_data), 32'(exp_q[0].d));
        end else begin
          chk("extra_access", 32'(addr), 32'h3fe);
        end
      end
      pulse = 1'b0; rdat = 16'h0;
      if (addr[9:0] != 10'h3fe && addr[9:0] >= 10'h200) begin
        s_i = int'((addr[9:0] - 10'h200) >> 6);
        if (!addr[10] && addr[5:0] == 6'h08) begin
          a_i = att[s_i] < 0 ? 0 : (att[s_i] > 3 ? 3 : att[s_i]);
          m_i = mode[s_i][a_i];
          tgt = lsn[s_i] ? 8'h14 : (UM[s_i] ? 8'h22 : 8'h13);
          stk = (m_i == M_STI && !lsn[s_i]) || (m_i == M_STL && lsn[s_i]);
          if (m_i == M_RACE) begin
            if (vis == int'(TMO)) begin pulse = 1'b1; rdat = {8'h00, tgt}; end
          end else if (hold == 2) begin
            pulse = 1'b1;
            if (stk) rdat = 16'h0000;
            else if (m_i == M_SLOW && polls < 3) rdat = {8'h00, tgt ^ 8'h01};
            else rdat = {8'h00, tgt};
          end
          if (pulse) begin
            polls++;
            if (rdat[7:0] == tgt && exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end else if (hold == 2) begin
          pulse = 1'b1;
          case (addr)
            11'h600: chk("mr_s0_tcp", 32'(wr_data), 32'h0021);
            11'h640: chk("mr_s1_udp", 32'(wr_data), 32'h0002);
            11'h644: chk("imr_s1_udp", 32'(wr_data), 32'h001c);
            11'h64a: chk("port_s1", 32'(wr_data), 32'd7001);
            11'h68a: chk("port_s2", 32'(wr_data), 32'd7002);
            11'h65a: chk("s1_no_kpal", 32'(addr), 32'h0);
            default: ;
          endcase
          if (addr[5:0] == 6'h02) begin
            if (wr_data == 16'h0010) att[s_i]++;
            else if (wr_data == 16'h0001) lsn[s_i] = 1'b0;
            else if (wr_data == 16'h0002) begin
              lsn[s_i] = 1'b1;
              if (UM[s_i]) chk("udp_no_listen", 32'(addr), 32'h0);
            end
          end
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      op_state = pulse; rd_data = rdat; op_prev = pulse;
    end
  end

  task automatic wait_done(input string nm);
    bit ok = 0;
    for (int i = 0; i < 8000 && !ok; i++) begin
      @(posedge clk); #2;
      ok = done;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
    chk({nm, "_ready"}, 32'(sock_ready), 32'(exp_ready));
    chk({nm, "_fail"}, 32'(sock_fail), 32'(exp_fail));
    chk({nm, "_q_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic hard_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    exp_q.delete(); exp_ready = '0; exp_fail = '0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic start_all();
    build(0, NS - 1);
    @(posedge clk); #2; enable = 1'b1;
    @(posedge clk); #2; enable = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic reconf(input int idx, input string nm);
    exp_ready[idx] = 1'b0; exp_fail[idx] = 1'b0;
    build(idx, idx);
    @(posedge clk); #2; reconf_req = 1'b1; reconf_idx = 3'(idx);
    @(posedge clk); #2; reconf_req = 1'b0;
    chk({nm, "_ready_drop"}, 32'(sock_ready[idx]), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_done_low"}, 32'(done), 32'd0);
    wait_done(nm);
  endtask

  task automatic ignored_reconf(input int idx);
    logic [NS-1:0] r0 = sock_ready;
    @(posedge clk); #2; reconf_req = 1'b1; reconf_idx = 3'(idx);
    @(posedge clk); #2; reconf_req = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("oor_done", 32'(done), 32'd1);
    chk("oor_busy", 32'(busy), 32'd0);
    chk("oor_ready", 32'(sock_ready), 32'(r0));
  endtask

  initial begin
    bit hit;
    rst = 1'b1; enable = 1'b0; reconf_req = 1'b0; reconf_idx = 3'd0;
    op_state = 1'b0; rd_data = 16'h0;
    exp_ready = '0; exp_fail = '0;
    for (int s = 0; s < 8; s++) begin set_modes(s, M_NORM, M_NORM, M_NORM); att[s] = -1; lsn[s] = 0; end
    repeat (3) @(posedge clk);
    #2;
    chk("rst_addr", 32'(addr), 32'h3fe);
    chk("rst_wr_data", 32'(wr_data), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(sock_ready), 32'd0);
    chk("rst_fail", 32'(sock_fail), 32'd0);
    rst = 1'b0;

    // Plain bring-up, socket 1 polls a few wrong statuses first.
    set_modes(0, M_NORM, M_NORM, M_NORM);
    set_modes(1, M_SLOW, M_NORM, M_NORM);
    set_modes(2, M_NORM, M_NORM, M_NORM);
    start_all();
    wait_done("bringup");
    chk("bringup_ready_lit", 32'(sock_ready), 32'h7);

    ignored_reconf(5);
    ignored_reconf(3);
    set_modes(2, M_SLOW, M_NORM, M_NORM);
    reconf(2, "reconf2");
    set_modes(1, M_RACE, M_NORM, M_NORM);
    reconf(1, "reconf1_race");

    // Socket 0 never initialises; socket 2 fails LISTEN once, then wins a race.
    hard_reset();
    set_modes(0, M_STI, M_STI, M_STI);
    set_modes(1, M_NORM, M_NORM, M_NORM);
    set_modes(2, M_STL, M_RACE, M_NORM);
    start_all();
    wait_done("retry");
    chk("retry_fail_lit", 32'(sock_fail), 32'h1);
    chk("retry_ready_lit", 32'(sock_ready), 32'h6);
    set_modes(0, M_RACE, M_NORM, M_NORM);
    reconf(0, "reconf0");

    // Reset while socket 1 is taking its parameters.
    hard_reset();
    for (int s = 0; s < NS; s++) set_modes(s, M_NORM, M_NORM, M_NORM);
    start_all();
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(posedge clk); #2;
      hit = (addr == 11'h640);
    end
    chk("mid_reached_s1_params", 32'(hit), 32'd1);
    chk("mid_ready_s0", 32'(sock_ready), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(addr), 32'h3fe);
    chk("mid_rst_wr_data", 32'(wr_data), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(sock_ready), 32'h0);
    chk("mid_rst_fail", 32'(sock_fail), 32'h0);
    exp_q.delete(); exp_ready = '0; exp_fail = '0;
    @(posedge clk); #2; rst = 1'b0;
    for (int s = 0; s < NS; s++) rand_modes(s);
    start_all();
    wait_done("restart");

    for (int r = 0; r < 3; r++) begin
      int idx;
      hard_reset();
      for (int s = 0; s < NS; s++) rand_modes(s);
      start_all();
      wait_done("rand_pass");
      idx = int'($urandom_range(0, NS - 1));
      rand_modes(idx);
      reconf(idx, "rand_reconf");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/w5300_multi_socket_conf.md
# w5300_multi_socket_conf

Parametrised successor to the single-socket TCP server configurator. It brings up NUM_SOCKETS W5300 sockets in sequence, each in TCP-server or UDP mode set by a per-socket mask. Each socket has a bounded retry count, a per-socket ready/fail status, and can be re-opened on request at run time. It sits between the common-register configurator and the W5300 bus controller, and drives the same addr/wr_data/op_state handshake.

## Interface
Parameters:
- NUM_SOCKETS, 2: sockets configured, indices 0..NUM_SOCKETS-1; legal range 1..8.
- UDP_MASK, 8'h00: bit n = 1 means socket n is UDP; 0 means TCP server.
- BASE_PORT, 16'd7000: socket n uses port BASE_PORT + n, 16-bit wrap.
- OP_TIMEOUT, 16'd50: cycle budget for each SSR wait state.
- MAX_RETRY, 3'd2: re-attempts after the first failure; a socket gets MAX_RETRY+1 attempts in total.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous and active-high.
- enable  in  1  starts the initial bring-up of all sockets; sampled in Idle.
- addr  out  11  {WR/RD flag from the W5300 package, 10-bit register address}.
- wr_data  out  16  write data; 0 for reads.
- rd_data  in  16  read data; valid in the cycle op_state is high.
- op_state  in  1  one-cycle pulse from the bus controller when the current access completes.
- reconf_req  in  1  requests re-open of socket reconf_idx; accepted only in Done.
- reconf_idx  in  3  socket index for reconf_req.
- busy  out  1  high in every state except Idle and Done.
- done  out  1  high in Done.
- sock_ready  out  NUM_SOCKETS  bit n set when socket n reaches LISTEN (TCP) or UDP (UDP) status.
- sock_fail  out  NUM_SOCKETS  bit n set when socket n has exhausted its retries.

## Operation
State machine states: Idle, Close, Params, Open, WaitInit, Listen, WaitStatus, Next, Done.

Transitions:
- Idle -> Close when enable is high. cur = 0, retry = 0.
- Close: drives {WR, Sn_CR(cur), Sn_CR_CLOSE}. Moves to Params on op_state.
- Params: one write per op_state, sequenced by op_cnt:
  - Sn_MR = Sn_MR_NO_DELAY_ACK|Sn_MR_P_TCP for TCP, Sn_MR_P_UDP for UDP.
  - Sn_PORTR = BASE_PORT+cur.
  - Sn_IMR: TCP = SENDOK|TIMEOUT|RECV|DISCONNECT|CONNECT; UDP = SENDOK|TIMEOUT|RECV.
  - Sn_KPALVTR_PROTOR = {8'd1, 8'd1}, TCP only. UDP skips this write.
  - Then -> Open.
- Open: drives {WR, Sn_CR(cur), Sn_CR_OPEN}. Moves to WaitInit on op_state.
- WaitInit: drives {RD, Sn_SSR(cur)}. On op_state:
  - TCP and rd_data[7:0] == SOCK_INIT -> Listen.
  - UDP and rd_data[7:0] == SOCK_UDP -> Next with success.
- Listen: drives {WR, Sn_CR(cur), Sn_CR_LISTEN}. Moves to WaitStatus on op_state.
- WaitStatus: drives {RD, Sn_SSR(cur)}. On op_state with rd_data[7:0] == SOCK_LISTEN -> Next with success.
- Timeout in WaitInit or WaitStatus:
  - retry < MAX_RETRY: retry++, -> Close.
  - Otherwise: set sock_fail[cur], -> Next.
- Next, success path: sets sock_ready[cur]. Then:
  - In initial bring-up with cur < NUM_SOCKETS-1: cur++, retry = 0, -> Close.
  - Otherwise -> Done.
- Done: if reconf_req is high and reconf_idx < NUM_SOCKETS: cur = reconf_idx, clear sock_ready[cur] and sock_fail[cur], retry = 0, mark single mode, -> Close. A single-mode pass ends in Done after Next.
- An out-of-range reconf_idx is ignored.
- Idle and Done drive {RD, 10'h3fe, 16'h0}.

## Timing
- Reset values: state Idle, addr = {RD, 10'h3fe}, wr_data 0, busy 0, done 0, sock_ready 0, sock_fail 0, internal counters 0.
- Reset asserted mid-sequence returns everything to these values immediately.
- addr and wr_data are combinational from state, op_cnt and cur.
- Each write occupies its bus slot until op_state. The next address appears the cycle after op_state.
- The timeout counter clears on entry to WaitInit/WaitStatus and increments every cycle there. Timeout fires when count >= OP_TIMEOUT.
- If op_state with a matching status arrives in the same cycle as the timeout, the match wins.
- A non-matching read keeps polling the same address.
- sock_ready and sock_fail update in the Next cycle. done rises one cycle after the final Next.
- Socket register address = Sn base + 0x40*cur, computed with the package socket-register function.
- enable is ignored outside Idle. reconf_req is ignored outside Done.

## Test plan
- Bring-up, NUM_SOCKETS=2, UDP_MASK=0, bus model with op_state 2 cycles after each address change, SSR returning 0x13 then 0x14:
  - Per socket: CLOSE, 4 param writes, OPEN, LISTEN.
  - Port writes are 7000 and 7001.
  - sock_ready = 2'b11, done = 1, sock_fail = 0.
- Mixed mode, UDP_MASK = 8'h02:
  - Socket 1 gets MR with Sn_MR_P_UDP, no KPALVTR write and no LISTEN.
  - SSR 0x22 -> sock_ready[1] = 1.
- Retry: SSR stuck at 0x00, OP_TIMEOUT=50, MAX_RETRY=2:
  - Exactly 3 CLOSE/OPEN attempts on socket 0, then sock_fail[0] = 1.
  - Socket 1 then configures normally and done = 1.
- Match-versus-timeout race: matching op_state lands on the timeout cycle -> success, no retry.
- Reconf: in Done, pulse reconf_req with idx 1:
  - sock_ready[1] drops, the full TCP sequence runs on socket 1 only, done returns.
  - idx 5 with NUM_SOCKETS=2 is ignored.
- Reset asserted during Params of socket 1: all outputs return to reset values on the same edge; a fresh enable restarts from socket 0.
